alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
Parametrised successor to the 3-bit, 2-opcode ALU. It handles WIDTH-bit unsigned operands with a 2*WIDTH-bit registered result and an 8-entry opcode set. Multiply is a multi-cycle shift-add, and a persistent accumulator supports running sums. It sits in the lab datapath behind a start/busy/done handshake so a sequencer or testbench can issue back-to-back operations.

Parameters:
WIDTH, 3, operand width in bits (WIDTH >= 2); result width is 2*WIDTH

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request; sampled only when busy=0
portA  input  WIDTH  operand A (unsigned)
portB  input  WIDTH  operand B (unsigned)
opcode  input  3  operation select, sampled with start
out  output  2*WIDTH  registered result; holds between operations
busy  output  1  high while a multiply is in progress
done  output  1  one-cycle pulse when out is updated
zero  output  1  registered; 1 when the last completed result was 0

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst): all state updates on the rising edge of clk, and rst=1 at an edge overrides every other input.
- Reset values: out=0, acc=0, busy=0, done=0, zero=0, FSM=IDLE, iteration counter=0.
- Opcodes: 0 ADD, 1 SUB, 2 MUL, 3 AND, 4 OR, 5 XOR, 6 ACC, 7 CLR.
- Width rules:
  - Operands are zero-extended to 2*WIDTH bits.
  - ADD/SUB wrap mod 2^(2*WIDTH); SUB of a smaller minuend yields the two's-complement pattern.
  - AND/OR/XOR operate on the zero-extended operands, so the upper WIDTH bits are 0.
  - MUL is the exact product and never overflows.
  - ACC: acc <= acc + zext(portA) mod 2^(2*WIDTH); out <= new acc value.
  - CLR: acc <= 0, out <= 0.
- Operand capture: portA, portB and opcode are latched at the edge where start=1 and busy=0. Later input changes do not affect an operation in flight.
- FSM states: IDLE, MUL.
  - IDLE with start=1 and opcode != MUL: out, zero and (for ACC/CLR) acc update at that edge. done=1 for the next cycle only. Latency is 1 cycle; the FSM stays in IDLE.
  - IDLE with start=1 and opcode == MUL: registers A, B, product=0 and counter=0, then moves to MUL with busy=1 visible the next cycle.
  - MUL, each edge: if B[counter]=1, product += A << counter; counter increments.
  - MUL, on the WIDTH-th MUL edge: out <= final product, zero updated, done=1 for one cycle, busy=0, return to IDLE.
  - MUL timing: with start at edge k, busy is high in cycles k+1..k+WIDTH, and out/done are valid in the cycle after edge k+WIDTH.
- Back-to-back: start may be asserted in the cycle where done=1 (busy=0) and is accepted at that edge.
- start while busy=1 is ignored: it is not queued and does not alter operands or acc.
- zero is updated only on edges that produce done, and equals (new out == 0). CLR therefore sets zero=1.
- Reset mid-MUL: the operation is aborted, no done pulse is produced, and all outputs take their reset values.
- start=0 in IDLE: all registers hold; done=0.
- Opcode inputs are don't-care while start=0 or busy=1.

Test Plan:
1. WIDTH=3, after reset: out=0, busy=0, done=0, zero=0. Then start, portA=4, portB=3, ADD -> next cycle out=7 (6'h07), done=1 for one cycle, zero=0; out still 7 two cycles later.
2. WIDTH=3, SUB portA=3, portB=4 -> out=6'h3F, done pulse. Then AND 6,3 -> out=2; XOR 5,5 -> out=0, zero=1.
3. WIDTH=3, MUL 7*7:
   - busy=1 for exactly 3 cycles; done rises the cycle after, with out=49.
   - A second start (ADD 1,1) during busy is ignored, so out ends at 49, not 2.
   - Issue ADD 1,1 in the done cycle -> out=2 one cycle later.
4. WIDTH=3, CLR, then ACC portA=5 three times -> out=5,10,15. Then ACC portA=7 repeatedly until wrap: after the 7th add out=64 mod 64 = 0, zero=1. Then CLR -> out=0.
5. WIDTH=3, start MUL 6*5, assert rst for one cycle on the 2nd busy cycle -> no done pulse ever; out=0, busy=0, acc=0. Next MUL 6*5 -> out=30.
6. WIDTH=8, MUL 255*255 -> out=65025 (16'hFE01) after 8 busy cycles. ADD 255+255 -> out=510, upper byte 1.

Source files
------------

// File: rtl/alu_seq.sv
// alu_seq: sequential ALU with WIDTH-bit unsigned operands and a 2*WIDTH-bit
// registered result. Single-cycle ops finish in IDLE. Multiply is a
// WIDTH-cycle shift-add. A persistent accumulator backs ACC/CLR.
module alu_seq #(
  parameter int unsigned WIDTH = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     portA,
  input  logic [WIDTH-1:0]     portB,
  input  logic [2:0]           opcode,
  output logic [2*WIDTH-1:0]   out,
  output logic                 busy,
  output logic                 done,
  output logic                 zero
);

  localparam int unsigned RW = 2 * WIDTH;
  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_OR  = 3'd4;
  localparam logic [2:0] OP_XOR = 3'd5;
  localparam logic [2:0] OP_ACC = 3'd6;
  localparam logic [2:0] OP_CLR = 3'd7;

  typedef enum logic {S_IDLE = 1'b0, S_MUL = 1'b1} state_t;

  state_t          state_q, state_n;
  logic [RW-1:0]   a_q, a_n;
  logic [WIDTH-1:0] b_q, b_n;
  logic [RW-1:0]   prod_q, prod_n;
  logic [CW-1:0]   cnt_q, cnt_n;
  logic [RW-1:0]   acc_q, acc_n;
  logic [RW-1:0]   out_q, out_n;
  logic            zero_q, zero_n;
  logic            done_q, done_n;
  logic [RW-1:0]   ax, bx;
  logic            last_step;

  assign ax        = RW'(portA);
  assign bx        = RW'(portB);
  assign last_step = (cnt_q == CW'(WIDTH - 1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_n;
    end
  end

  // Next-state: enter MUL on an accepted multiply, leave after WIDTH steps
  always_comb begin
    state_n = state_q;
    if (state_q == S_IDLE) begin
      if (start && (opcode == OP_MUL)) begin
        state_n = S_MUL;
      end
    end else begin
      if (last_step) begin
        state_n = S_IDLE;
      end
    end
  end

  // Datapath next values: single-cycle ops, operand capture, shift-add steps
  always_comb begin
    a_n    = a_q;
    b_n    = b_q;
    prod_n = prod_q;
    cnt_n  = cnt_q;
    acc_n  = acc_q;
    out_n  = out_q;
    zero_n = zero_q;
    done_n = 1'b0;
    if (state_q == S_IDLE) begin
      if (start) begin
        case (opcode)
          OP_ADD: out_n = ax + bx;
          OP_SUB: out_n = ax - bx;
          OP_AND: out_n = ax & bx;
          OP_OR:  out_n = ax | bx;
          OP_XOR: out_n = ax ^ bx;
          OP_ACC: begin
            acc_n = acc_q + ax;
            out_n = acc_q + ax;
          end
          OP_CLR: begin
            acc_n = '0;
            out_n = '0;
          end
          default: begin
            a_n    = ax;
            b_n    = portB;
            prod_n = '0;
            cnt_n  = '0;
          end
        endcase
        if (opcode != OP_MUL) begin
          done_n = 1'b1;
          zero_n = (out_n == '0);
        end
      end
    end else begin
      prod_n = prod_q + (b_q[cnt_q] ? (a_q << cnt_q) : '0);
      cnt_n  = cnt_q + CW'(1);
      if (last_step) begin
        out_n  = prod_n;
        zero_n = (prod_n == '0);
        done_n = 1'b1;
      end
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      prod_q <= '0;
      cnt_q  <= '0;
      acc_q  <= '0;
      out_q  <= '0;
      zero_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      a_q    <= a_n;
      b_q    <= b_n;
      prod_q <= prod_n;
      cnt_q  <= cnt_n;
      acc_q  <= acc_n;
      out_q  <= out_n;
      zero_q <= zero_n;
      done_q <= done_n;
    end
  end

  assign out  = out_q;
  assign zero = zero_q;
  assign done = done_q;
  assign busy = (state_q == S_MUL);

endmodule

// File: tb/tb_alu_seq.sv
// Randomised and directed bench for alu_seq at WIDTH=3 and WIDTH=8,
// checked against an arithmetic reference model.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start3, start8;
  logic [2:0]  a3, b3, op3;
  logic [7:0]  a8, b8;
  logic [2:0]  op8;
  logic [5:0]  out3;
  logic [15:0] out8;
  logic        busy3, done3, zero3;
  logic        busy8, done8, zero8;

  int n_checks = 0;
  int n_errors = 0;
  longint acc_m [2];
  longint last_m [2];

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(3)) u3 (
    .clk(clk), .rst(rst), .start(start3), .portA(a3), .portB(b3),
    .opcode(op3), .out(out3), .busy(busy3), .done(done3), .zero(zero3)
  );

  alu_seq #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .start(start8), .portA(a8), .portB(b8),
    .opcode(op8), .out(out8), .busy(busy8), .done(done8), .zero(zero8)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] get_out(input int w);
    return (w == 3) ? 16'(out3) : out8;
  endfunction
  function automatic logic get_busy(input int w);
    return (w == 3) ? busy3 : busy8;
  endfunction
  function automatic logic get_done(input int w);
    return (w == 3) ? done3 : done8;
  endfunction
  function automatic logic get_zero(input int w);
    return (w == 3) ? zero3 : zero8;
  endfunction

  task automatic drive(input int w, input bit s, input int op, input int a, input int b);
    if (w == 3) begin
      start3 = s; op3 = 3'(op); a3 = 3'(a); b3 = 3'(b);
    end else begin
      start8 = s; op8 = 3'(op); a8 = 8'(a); b8 = 8'(b);
    end
  endtask

  task automatic set_start(input int w, input bit s);
    if (w == 3) start3 = s;
    else        start8 = s;
  endtask

  // Reference result from the opcode definitions, updating the model accumulator
  function automatic longint model(input int w, input int op, input int a, input int b);
    int     idx  = (w == 3) ? 0 : 1;
    longint mask = (64'sd1 <<< (2 * w)) - 1;
    longint r;
    case (op)
      0: r = (longint'(a) + longint'(b)) & mask;
      1: r = (longint'(a) - longint'(b)) & mask;
      2: r = longint'(a) * longint'(b);
      3: r = longint'(a & b);
      4: r = longint'(a | b);
      5: r = longint'(a ^ b);
      6: begin acc_m[idx] = (acc_m[idx] + longint'(a)) & mask; r = acc_m[idx]; end
      default: begin acc_m[idx] = 0; r = 0; end
    endcase
    last_m[idx] = r;
    return r;
  endfunction

  // Issue one operation from mid-cycle; returns mid-cycle in the done cycle
  task automatic run_op(input int w, input int op, input int a, input int b, input bit poke);
    longint exp;
    exp = model(w, op, a, b);
    drive(w, 1'b1, op, a, b);
    @(posedge clk); #1;
    set_start(w, 1'b0);
    if (op == 2) begin
      for (int i = 0; i < w; i++) begin
        check($sformatf("busy_w%0d_c%0d", w, i), 16'(get_busy(w)), 16'd1);
        check($sformatf("nodone_w%0d_c%0d", w, i), 16'(get_done(w)), 16'd0);
        if (poke && i == 0) drive(w, 1'b1, 0, 1, 1);
        @(posedge clk); #1;
        set_start(w, 1'b0);
      end
    end
    check($sformatf("done_w%0d_op%0d", w, op), 16'(get_done(w)), 16'd1);
    check($sformatf("idle_w%0d_op%0d", w, op), 16'(get_busy(w)), 16'd0);
    check($sformatf("out_w%0d_op%0d_%0d_%0d", w, op, a, b), get_out(w), 16'(exp));
    check($sformatf("zero_w%0d_op%0d", w, op), 16'(get_zero(w)), 16'(exp == 0));
  endtask

  // One quiet cycle: done must drop and out must hold
  task automatic idle(input int w);
    int idx = (w == 3) ? 0 : 1;
    set_start(w, 1'b0);
    @(posedge clk); #1;
    check($sformatf("pulse_w%0d", w), 16'(get_done(w)), 16'd0);
    check($sformatf("hold_w%0d", w), get_out(w), 16'(last_m[idx]));
  endtask

  initial begin
    rst = 1'b1;
    drive(3, 1'b0, 0, 0, 0);
    drive(8, 1'b0, 0, 0, 0);
    acc_m[0] = 0; acc_m[1] = 0; last_m[0] = 0; last_m[1] = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_out", 16'(out3), 16'd0);
    check("rst_busy", 16'(busy3), 16'd0);
    check("rst_done", 16'(done3), 16'd0);
    check("rst_zero", 16'(zero3), 16'd0);
    check("rst_out8", out8, 16'd0);

    // ADD, then hold for two cycles
    run_op(3, 0, 4, 3, 1'b0);
    check("add_7", 16'(out3), 16'h07);
    idle(3);
    idle(3);

    // SUB underflow, AND, XOR to zero
    run_op(3, 1, 3, 4, 1'b0);
    check("sub_3f", 16'(out3), 16'h3F);
    run_op(3, 3, 6, 3, 1'b0);
    run_op(3, 5, 5, 5, 1'b0);
    check("xor_zero", 16'(zero3), 16'd1);

    // MUL 7*7 with an ignored start while busy, then back-to-back ADD
    run_op(3, 2, 7, 7, 1'b1);
    check("mul_49", 16'(out3), 16'd49);
    run_op(3, 0, 1, 1, 1'b0);
    idle(3);

    // Accumulator and wrap
    run_op(3, 7, 0, 0, 1'b0);
    for (int i = 0; i < 3; i++) run_op(3, 6, 5, 0, 1'b0);
    check("acc_15", 16'(out3), 16'd15);
    for (int i = 0; i < 7; i++) run_op(3, 6, 7, 0, 1'b0);
    check("acc_wrap", 16'(out3), 16'd0);
    check("acc_wrap_zero", 16'(zero3), 16'd1);
    run_op(3, 7, 0, 0, 1'b0);
    idle(3);

    // Reset on the 2nd busy cycle of a multiply
    drive(3, 1'b1, 2, 6, 5);
    @(posedge clk); #1;
    set_start(3, 1'b0);
    @(posedge clk); #1;
    check("abort_busy", 16'(busy3), 16'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    acc_m[0] = 0; acc_m[1] = 0; last_m[0] = 0; last_m[1] = 0;
    check("abort_out", 16'(out3), 16'd0);
    check("abort_idle", 16'(busy3), 16'd0);
    check("abort_zero", 16'(zero3), 16'd0);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("abort_nodone_%0d", i), 16'(done3), 16'd0);
      @(posedge clk); #1;
    end
    run_op(3, 6, 0, 0, 1'b0);
    run_op(3, 2, 6, 5, 1'b0);
    check("mul_30", 16'(out3), 16'd30);

    // WIDTH=8 corners
    run_op(8, 2, 255, 255, 1'b1);
    check("mul8_fe01", out8, 16'hFE01);
    run_op(8, 0, 255, 255, 1'b0);
    check("add8_510", out8, 16'd510);
    idle(8);

    // Randomised operations on both widths
    for (int n = 0; n < 80; n++) begin
      int w;
      int op;
      int lim;
      w   = ($urandom_range(0, 1) == 0) ? 3 : 8;
      lim = (w == 3) ? 7 : 255;
      op  = int'($urandom_range(0, 7));
      run_op(w, op, int'($urandom_range(0, lim)), int'($urandom_range(0, lim)),
             1'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) == 0) idle(w);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
